ddr3_port_arbiter: RTL and testbench

DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

---
 rtl/ddr3_port_arbiter_if.sv | 17 +
 rtl/ddr3_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_port_arbiter_if.sv
// Requester-side handshake bundle for one DDR3 arbiter port.
// The requester drives the master modport; the arbiter uses slave.
interface ddr3_port_arbiter_if;
    logic [2:0]  cmd;
    logic [25:0] addr;
    logic [1:0]  sz;
    logic [2:0]  op;
    logic [15:0] din;
    logic        gnt;
    logic        wack;
    logic [15:0] rdata;
    logic [25:0] raddr;
    logic        rvalid;

    modport master (output cmd, addr, sz, op, din, input gnt, wack, rdata, raddr, rvalid);
    modport slave  (input cmd, addr, sz, op, din, output gnt, wack, rdata, raddr, rvalid);
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Two-port DDR3 host arbiter: grants commands, streams BLW bursts, routes returned
// read words by owner tag. Define DDR3_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module ddr3_port_arbiter #(
    parameter int TAG_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    ddr3_port_arbiter_if.slave p0,
    ddr3_port_arbiter_if.slave p1,
    output logic [2:0]         cmd,
    output logic [25:0]        addr,
    output logic [1:0]         sz,
    output logic [2:0]         op,
    output logic [15:0]        din,
    input  logic               ready,
    input  logic               notfull,
    input  logic [5:0]         fillcount,
    input  logic [15:0]        dout,
    input  logic [25:0]        raddr,
    input  logic               validout,
    output logic               read
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [2:0] C_SCR = 3'd1, C_SCW = 3'd2, C_BLR = 3'd3,
                           C_BLW = 3'd4, C_ATR = 3'd5, C_ATW = 3'd6;

    typedef enum logic       {IDLE, BURST}      wstate_e;
    typedef enum logic [1:0] {RIDLE, RPOP, RGAP} rstate_e;
    typedef struct packed { logic own; logic [4:0] last; } tag_t;

    logic [1:0][2:0]  req_cmd;
    logic [1:0][25:0] req_addr;
    logic [1:0][1:0]  req_sz;
    logic [1:0][2:0]  req_op;
    logic [1:0][15:0] req_din;
    assign req_cmd  = {p1.cmd,  p0.cmd};
    assign req_addr = {p1.addr, p0.addr};
    assign req_sz   = {p1.sz,   p0.sz};
    assign req_op   = {p1.op,   p0.op};
    assign req_din  = {p1.din,  p0.din};

    wstate_e          wstate_q, wstate_d;
    logic [4:0]       bcnt_q, bcnt_d;
    logic             bown_q, bown_d;
    rstate_e          rstate_q, rstate_d;
    logic             read_q, read_d;
    logic [4:0]       rcnt_q, rcnt_d;
    tag_t             tag_mem_q [TAG_DEPTH];
    tag_t             tag_mem_d [TAG_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      tcnt_q, tcnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0][15:0] rdata_q, rdata_d;
    logic [1:0][25:0] raddr_q, raddr_d;

    logic [1:0]       elig, gnt, wack;
    logic [1:0][5:0]  blen;
    logic             win, any, tfull, push, tag_pop;
    tag_t             push_tag, head;
`ifdef DDR3_ARB_ROUND_ROBIN_EN
    logic             ptr_q, ptr_d;
`endif

    // Command side: eligibility, winner select and burst streaming.
    always_comb begin
        tfull = (tcnt_q == TAG_DEPTH[PW:0]);
        for (int i = 0; i < 2; i++) begin
            blen[i] = {({1'b0, req_sz[i]} + 3'd1), 3'b000};
            unique case (req_cmd[i])
                C_SCR, C_BLR: elig[i] = !tfull;
                C_SCW, C_ATW: elig[i] = (fillcount < 6'd32);
                C_ATR:        elig[i] = (fillcount < 6'd32) && !tfull;
                C_BLW:        elig[i] = (({1'b0, fillcount} + {1'b0, blen[i]}) <= 7'd32);
                default:      elig[i] = 1'b0;
            endcase
            elig[i] = elig[i] && ready && notfull && !reset && (wstate_q == IDLE);
        end
        any = |elig;
`ifdef DDR3_ARB_ROUND_ROBIN_EN
        win   = (elig[0] && elig[1]) ? ptr_q : elig[1];
        ptr_d = any ? !win : ptr_q;
`else
        win = !elig[0];
`endif
        gnt  = '0;
        cmd  = 3'd0;
        addr = req_addr[win];
        sz   = req_sz[win];
        op   = req_op[win];
        din  = req_din[win];
        if (any) begin
            gnt[win] = 1'b1;
            cmd      = req_cmd[win];
        end
        wack = '0;
        if (wstate_q == BURST) begin
            din          = req_din[bown_q];
            wack[bown_q] = !reset;
        end

        wstate_d = wstate_q;
        bcnt_d   = bcnt_q;
        bown_d   = bown_q;
        if (wstate_q == IDLE) begin
            if (any && req_cmd[win] == C_BLW) begin
                wstate_d = BURST;
                bcnt_d   = 5'(blen[win] - 6'd1);
                bown_d   = win;
            end
        end else begin
            bcnt_d = bcnt_q - 5'd1;
            if (bcnt_q == 5'd1) wstate_d = IDLE;
        end

        push          = any && (req_cmd[win] == C_SCR || req_cmd[win] == C_BLR || req_cmd[win] == C_ATR);
        push_tag.own  = win;
        push_tag.last = (req_cmd[win] == C_BLR) ? 5'(blen[win] - 6'd1) : 5'd0;
    end

    // Return side: pop, route to owner, then one gap cycle for the registered validout.
    always_comb begin
        head     = tag_mem_q[rd_ptr_q];
        rstate_d = rstate_q;
        read_d   = 1'b0;
        rcnt_d   = rcnt_q;
        tag_pop  = 1'b0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        raddr_d  = raddr_q;
        unique case (rstate_q)
            RIDLE: if (validout && tcnt_q != '0) begin
                rstate_d = RPOP;
                read_d   = 1'b1;
            end
            RPOP: begin
                rstate_d           = RGAP;
                rvalid_d[head.own] = 1'b1;
                rdata_d[head.own]  = dout;
                raddr_d[head.own]  = raddr;
                if (rcnt_q == head.last) begin
                    tag_pop = 1'b1;
                    rcnt_d  = 5'd0;
                end else begin
                    rcnt_d = rcnt_q + 5'd1;
                end
            end
            default: rstate_d = RIDLE;
        endcase

        tag_mem_d = tag_mem_q;
        if (push) tag_mem_d[wr_ptr_q] = push_tag;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(tag_pop);
        tcnt_d   = tcnt_q + (PW+1)'(push) - (PW+1)'(tag_pop);
    end

    always_ff @(posedge clk) tag_mem_q <= tag_mem_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q <= IDLE;
            bcnt_q   <= '0;
            bown_q   <= 1'b0;
            rstate_q <= RIDLE;
            read_q   <= 1'b0;
            rcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tcnt_q   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            raddr_q  <= '0;
`ifdef DDR3_ARB_ROUND_ROBIN_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            wstate_q <= wstate_d;
            bcnt_q   <= bcnt_d;
            bown_q   <= bown_d;
            rstate_q <= rstate_d;
            read_q   <= read_d;
            rcnt_q   <= rcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tcnt_q   <= tcnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            raddr_q  <= raddr_d;
`ifdef DDR3_ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign read      = read_q;
    assign p0.gnt    = gnt[0];
    assign p1.gnt    = gnt[1];
    assign p0.wack   = wack[0];
    assign p1.wack   = wack[1];
    assign p0.rvalid = rvalid_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p0.rdata  = rdata_q[0];
    assign p1.rdata  = rdata_q[1];
    assign p0.raddr  = raddr_q[0];
    assign p1.raddr  = raddr_q[1];
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Bench for ddr3_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_ddr3_port_arbiter;
    localparam int TAG_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cmd;
    logic [25:0] addr;
    logic [1:0]  sz;
    logic [2:0]  op;
    logic [15:0] din;
    logic        ready, notfull;
    logic [5:0]  fillcount;
    logic [15:0] dout;
    logic [25:0] raddr;
    logic        validout;
    logic        read;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    ddr3_port_arbiter_if p0_if ();
    ddr3_port_arbiter_if p1_if ();

    ddr3_port_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .reset(reset), .p0(p0_if), .p1(p1_if),
        .cmd(cmd), .addr(addr), .sz(sz), .op(op), .din(din),
        .ready(ready), .notfull(notfull), .fillcount(fillcount),
        .dout(dout), .raddr(raddr), .validout(validout), .read(read)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [2:0] c, input logic [1:0] s);
        if (p == 0) begin
            p0_if.cmd = c;
            p0_if.sz  = s;
        end else begin
            p1_if.cmd = c;
            p1_if.sz  = s;
        end
    endtask

    task automatic idle_inputs();
        set_req(0, 3'd0, 2'd0);
        set_req(1, 3'd0, 2'd0);
        p0_if.addr = 26'h0000123; p0_if.op = 3'd1; p0_if.din = 16'h1111;
        p1_if.addr = 26'h0000456; p1_if.op = 3'd2; p1_if.din = 16'h2222;
        ready = 1'b1; notfull = 1'b1; fillcount = 6'd0;
        validout = 1'b0; dout = 16'h0; raddr = 26'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic model_elig(input logic [2:0] c, input logic [1:0] s, input int qsize);
        int   words = (int'(s) + 1) * 8;
        logic room  = (qsize < TAG_DEPTH);
        logic fok   = (int'(fillcount) < 32);
        if (!ready || !notfull) return 1'b0;
        case (c)
            3'd1, 3'd3: return room;
            3'd2, 3'd6: return fok;
            3'd5:       return fok && room;
            3'd4:       return (int'(fillcount) + words) <= 32;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        set_req(0, 3'd1, 2'd0);
        set_req(1, 3'd2, 2'd0);
        validout = 1'b1;
        tick();
        @(negedge clk);
        nvec++; if ({p1_if.gnt, p0_if.gnt} !== 2'b00) begin nerr++; $display("FAIL reset_gnt got %b want 00", {p1_if.gnt, p0_if.gnt}); end
        nvec++; if (cmd !== 3'd0) begin nerr++; $display("FAIL reset_cmd got %0d want 0", cmd); end
        nvec++; if (read !== 1'b0) begin nerr++; $display("FAIL reset_read got %b want 0", read); end
        nvec++; if ({p1_if.wack, p0_if.wack, p1_if.rvalid, p0_if.rvalid} !== 4'b0) begin nerr++; $display("FAIL reset_strobes got %b want 0000", {p1_if.wack, p0_if.wack, p1_if.rvalid, p0_if.rvalid}); end
        nvec++; if ({p1_if.rdata, p0_if.rdata} !== 32'h0) begin nerr++; $display("FAIL reset_rdata got %h want 0", {p1_if.rdata, p0_if.rdata}); end
        nvec++; if ({p1_if.raddr, p0_if.raddr} !== 52'h0) begin nerr++; $display("FAIL reset_raddr got %h want 0", {p1_if.raddr, p0_if.raddr}); end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_tie();
        logic [1:0] want;
        do_reset();
        set_req(0, 3'd1, 2'd0);
        set_req(1, 3'd1, 2'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
`ifdef DDR3_ARB_ROUND_ROBIN_EN
            want = (c == 1) ? 2'b10 : 2'b01;
`else
            want = 2'b01;
`endif
            nvec++; if ({p1_if.gnt, p0_if.gnt} !== want) begin nerr++; $display("FAIL tie_gnt cyc%0d got %b want %b", c, {p1_if.gnt, p0_if.gnt}, want); end
            nvec++; if (cmd !== 3'd1) begin nerr++; $display("FAIL tie_cmd cyc%0d got %0d want 1", c, cmd); end
            tick();
        end
    endtask

    task automatic test_blw_burst();
        int nwack = 0;
        do_reset();
        set_req(0, 3'd4, 2'd1);
        set_req(1, 3'd2, 2'd0);
        @(negedge clk);
        nvec++; if ({p1_if.gnt, p0_if.gnt} !== 2'b01) begin nerr++; $display("FAIL blw_gnt got %b want 01", {p1_if.gnt, p0_if.gnt}); end
        nvec++; if (cmd !== 3'd4) begin nerr++; $display("FAIL blw_cmd got %0d want 4", cmd); end
        tick();
        set_req(0, 3'd0, 2'd0);
        for (int c = 0; c < 15; c++) begin
            p0_if.din = 16'($urandom);
            @(negedge clk);
            if (p0_if.wack === 1'b1) nwack++;
            nvec++; if ({p1_if.wack, p0_if.wack, p1_if.gnt, cmd} !== {2'b01, 1'b0, 3'd0}) begin nerr++; $display("FAIL blw_burst cyc%0d got wack=%b%b gnt1=%b cmd=%0d want wack=01 gnt1=0 cmd=0", c, p1_if.wack, p0_if.wack, p1_if.gnt, cmd); end
            nvec++; if (din !== p0_if.din) begin nerr++; $display("FAIL blw_din cyc%0d got %h want %h", c, din, p0_if.din); end
            tick();
        end
        @(negedge clk);
        nvec++; if (nwack !== 15) begin nerr++; $display("FAIL blw_wack_count got %0d want 15", nwack); end
        nvec++; if ({p0_if.wack, p1_if.gnt, cmd} !== {1'b0, 1'b1, 3'd2}) begin nerr++; $display("FAIL blw_after got wack0=%b gnt1=%b cmd=%0d want 0 1 2", p0_if.wack, p1_if.gnt, cmd); end
        tick();
    endtask

    task automatic test_fill_limits();
        do_reset();
        fillcount = 6'd1;
        set_req(0, 3'd4, 2'd3);
        set_req(1, 3'd1, 2'd0);
        @(negedge clk);
        nvec++; if ({p1_if.gnt, p0_if.gnt} !== 2'b10) begin nerr++; $display("FAIL blw_block got %b want 10", {p1_if.gnt, p0_if.gnt}); end
        tick();
        set_req(1, 3'd0, 2'd0);
        @(negedge clk);
        nvec++; if ({p0_if.gnt, cmd} !== {1'b0, 3'd0}) begin nerr++; $display("FAIL blw_still_block got gnt0=%b cmd=%0d want 0 0", p0_if.gnt, cmd); end
        tick();
        fillcount = 6'd0;
        @(negedge clk);
        nvec++; if (p0_if.gnt !== 1'b1) begin nerr++; $display("FAIL blw_exact_fit got %b want 1", p0_if.gnt); end
        tick();
        do_reset();
        fillcount = 6'd32;
        set_req(1, 3'd2, 2'd0);
        @(negedge clk);
        nvec++; if (p1_if.gnt !== 1'b0) begin nerr++; $display("FAIL scw_full got %b want 0", p1_if.gnt); end
        tick();
        fillcount = 6'd31;
        @(negedge clk);
        nvec++; if (p1_if.gnt !== 1'b1) begin nerr++; $display("FAIL scw_31 got %b want 1", p1_if.gnt); end
        tick();
    endtask

    task automatic test_tag_full();
        do_reset();
        for (int k = 0; k < TAG_DEPTH; k++) begin
            set_req(0, 3'd1, 2'd0);
            @(negedge clk);
            nvec++; if (p0_if.gnt !== 1'b1) begin nerr++; $display("FAIL tag_fill %0d got %b want 1", k, p0_if.gnt); end
            tick();
        end
        set_req(1, 3'd5, 2'd0);
        @(negedge clk);
        nvec++; if ({p1_if.gnt, p0_if.gnt} !== 2'b00) begin nerr++; $display("FAIL tag_full_block got %b want 00", {p1_if.gnt, p0_if.gnt}); end
        tick();
        set_req(1, 3'd2, 2'd0);
        @(negedge clk);
        nvec++; if ({p1_if.gnt, p0_if.gnt} !== 2'b10) begin nerr++; $display("FAIL tag_full_scw got %b want 10", {p1_if.gnt, p0_if.gnt}); end
        tick();
        set_req(1, 3'd0, 2'd0);
        validout = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nvec++; if ({p0_if.gnt, read} !== {c == 2, c == 1}) begin nerr++; $display("FAIL tag_reopen cyc%0d got gnt0=%b read=%b want %b %b", c, p0_if.gnt, read, c == 2, c == 1); end
            tick();
        end
    endtask

    task automatic test_return();
        int          pops = 0;
        int          cap_own = 0;
        logic        pend = 1'b0;
        logic        prev_read = 1'b0;
        logic [15:0] cap_d = '0;
        logic [25:0] cap_a = '0;
        do_reset();
        set_req(1, 3'd3, 2'd0);
        @(negedge clk);
        nvec++; if (p1_if.gnt !== 1'b1) begin nerr++; $display("FAIL ret_blr_gnt got %b want 1", p1_if.gnt); end
        tick();
        set_req(1, 3'd0, 2'd0);
        set_req(0, 3'd1, 2'd0);
        @(negedge clk);
        nvec++; if (p0_if.gnt !== 1'b1) begin nerr++; $display("FAIL ret_scr_gnt got %b want 1", p0_if.gnt); end
        tick();
        set_req(0, 3'd0, 2'd0);
        validout = 1'b1;
        for (int c = 0; c < 45; c++) begin
            dout  = 16'($urandom);
            raddr = 26'($urandom);
            @(negedge clk);
            nvec++;
            if (pend) begin
                if ({p1_if.rvalid, p0_if.rvalid} !== ((cap_own == 1) ? 2'b10 : 2'b01)) begin nerr++; $display("FAIL ret_rvalid word%0d got %b want owner %0d", pops - 1, {p1_if.rvalid, p0_if.rvalid}, cap_own); end
                nvec++;
                if (((cap_own == 1) ? {p1_if.rdata, p1_if.raddr} : {p0_if.rdata, p0_if.raddr}) !== {cap_d, cap_a}) begin nerr++; $display("FAIL ret_data word%0d got %h want %h", pops - 1, (cap_own == 1) ? {p1_if.rdata, p1_if.raddr} : {p0_if.rdata, p0_if.raddr}, {cap_d, cap_a}); end
                pend = 1'b0;
            end else if ({p1_if.rvalid, p0_if.rvalid} !== 2'b00) begin
                nerr++; $display("FAIL ret_idle_rvalid cyc%0d got %b want 00", c, {p1_if.rvalid, p0_if.rvalid});
            end
            if (read === 1'b1) begin
                nvec++; if (prev_read) begin nerr++; $display("FAIL ret_read_b2b cyc%0d got 11 want 10", c); end
                cap_own = (pops < 8) ? 1 : 0;
                cap_d = dout;
                cap_a = raddr;
                pend = 1'b1;
                pops++;
            end
            prev_read = read;
            tick();
        end
        validout = 1'b0;
        nvec++; if (pops !== 9) begin nerr++; $display("FAIL ret_pop_count got %0d want 9", pops); end
    endtask

    task automatic test_reset_burst();
        do_reset();
        set_req(0, 3'd4, 2'd0);
        @(negedge clk);
        nvec++; if (p0_if.gnt !== 1'b1) begin nerr++; $display("FAIL rb_gnt got %b want 1", p0_if.gnt); end
        tick();
        set_req(0, 3'd0, 2'd0);
        tick();
        tick();
        @(negedge clk);
        nvec++; if (p0_if.wack !== 1'b1) begin nerr++; $display("FAIL rb_in_burst got %b want 1", p0_if.wack); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        nvec++; if ({p1_if.wack, p0_if.wack, p1_if.gnt, p0_if.gnt, cmd} !== 7'b0) begin nerr++; $display("FAIL rb_idle got wack=%b%b gnt=%b%b cmd=%0d want all 0", p1_if.wack, p0_if.wack, p1_if.gnt, p0_if.gnt, cmd); end
        tick();
        set_req(1, 3'd2, 2'd0);
        @(negedge clk);
        nvec++; if ({p1_if.gnt, cmd} !== {1'b1, 3'd2}) begin nerr++; $display("FAIL rb_new_gnt got gnt1=%b cmd=%0d want 1 2", p1_if.gnt, cmd); end
        tick();
    endtask

    task automatic test_random();
        int          burst_left = 0, burst_own = 0, phase = 0, rr = 0, win, qs;
        int          tag_own[$];
        int          tag_left[$];
        logic [15:0] m_rdata [2];
        logic [25:0] m_raddr [2];
        logic [1:0]  m_rvalid = '0, nx_rvalid, el, egnt, ewack;
        logic [2:0]  rc [2];
        logic [1:0]  rs [2];
        logic [25:0] ra [2];
        logic [2:0]  ro [2];
        logic [15:0] rd [2];
        logic [2:0]  ecmd;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            m_rdata[p] = '0; m_raddr[p] = '0;
            rc[p] = 3'd0; rs[p] = 2'd0; ra[p] = '0; ro[p] = '0; rd[p] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if ((rc[p] == 3'd0 || rc[p] == 3'd7) && $urandom_range(0, 1) == 1) begin
                    rc[p] = 3'($urandom_range(0, 7));
                    rs[p] = 2'($urandom);
                    ra[p] = 26'($urandom);
                    ro[p] = 3'($urandom);
                end
                rd[p] = 16'($urandom);
            end
            p0_if.cmd = rc[0]; p0_if.sz = rs[0]; p0_if.addr = ra[0]; p0_if.op = ro[0]; p0_if.din = rd[0];
            p1_if.cmd = rc[1]; p1_if.sz = rs[1]; p1_if.addr = ra[1]; p1_if.op = ro[1]; p1_if.din = rd[1];
            ready     = ($urandom_range(0, 9) != 0);
            notfull   = ($urandom_range(0, 9) != 0);
            fillcount = 6'($urandom_range(0, 32));
            validout  = 1'($urandom_range(0, 1));
            dout      = 16'($urandom);
            raddr     = 26'($urandom);

            qs = tag_own.size();
            for (int p = 0; p < 2; p++) el[p] = (burst_left == 0) && model_elig(rc[p], rs[p], qs);
`ifdef DDR3_ARB_ROUND_ROBIN_EN
            win = (el == 2'b11) ? rr : (el[1] ? 1 : 0);
`else
            win = el[0] ? 0 : 1;
`endif
            egnt  = '0;
            ecmd  = 3'd0;
            ewack = '0;
            if (el != 2'b00) begin egnt[win] = 1'b1; ecmd = rc[win]; end
            if (burst_left > 0) ewack[burst_own] = 1'b1;

            @(negedge clk);
            nvec++; if ({p1_if.gnt, p0_if.gnt} !== egnt) begin nerr++; $display("FAIL rnd_gnt cyc%0d got %b want %b", cyc, {p1_if.gnt, p0_if.gnt}, egnt); end
            nvec++; if (cmd !== ecmd) begin nerr++; $display("FAIL rnd_cmd cyc%0d got %0d want %0d", cyc, cmd, ecmd); end
            nvec++; if ({p1_if.wack, p0_if.wack} !== ewack) begin nerr++; $display("FAIL rnd_wack cyc%0d got %b want %b", cyc, {p1_if.wack, p0_if.wack}, ewack); end
            if (el != 2'b00) begin
                nvec++; if ({addr, sz, op, din} !== {ra[win], rs[win], ro[win], rd[win]}) begin nerr++; $display("FAIL rnd_mux cyc%0d got %h want %h", cyc, {addr, sz, op, din}, {ra[win], rs[win], ro[win], rd[win]}); end
            end
            if (burst_left > 0) begin
                nvec++; if (din !== rd[burst_own]) begin nerr++; $display("FAIL rnd_bdin cyc%0d got %h want %h", cyc, din, rd[burst_own]); end
            end
            nvec++; if (read !== (phase == 1)) begin nerr++; $display("FAIL rnd_read cyc%0d got %b want %b", cyc, read, phase == 1); end
            nvec++; if ({p1_if.rvalid, p0_if.rvalid} !== m_rvalid) begin nerr++; $display("FAIL rnd_rvalid cyc%0d got %b want %b", cyc, {p1_if.rvalid, p0_if.rvalid}, m_rvalid); end
            nvec++; if ({p1_if.rdata, p0_if.rdata, p1_if.raddr, p0_if.raddr} !== {m_rdata[1], m_rdata[0], m_raddr[1], m_raddr[0]}) begin nerr++; $display("FAIL rnd_rdata cyc%0d got %h want %h", cyc, {p1_if.rdata, p0_if.rdata, p1_if.raddr, p0_if.raddr}, {m_rdata[1], m_rdata[0], m_raddr[1], m_raddr[0]}); end

            @(posedge clk);
            nx_rvalid = '0;
            if (phase == 1) begin
                m_rdata[tag_own[0]] = dout;
                m_raddr[tag_own[0]] = raddr;
                nx_rvalid[tag_own[0]] = 1'b1;
                tag_left[0] = tag_left[0] - 1;
                if (tag_left[0] == 0) begin
                    void'(tag_own.pop_front());
                    void'(tag_left.pop_front());
                end
            end
            if (phase == 0) phase = (validout && qs > 0) ? 1 : 0;
            else            phase = (phase == 1) ? 2 : 0;
            if (burst_left > 0) burst_left--;
            if (el != 2'b00) begin
                if (rc[win] == 3'd1 || rc[win] == 3'd5) begin tag_own.push_back(win); tag_left.push_back(1); end
                if (rc[win] == 3'd3) begin tag_own.push_back(win); tag_left.push_back((int'(rs[win]) + 1) * 8); end
                if (rc[win] == 3'd4) begin burst_left = (int'(rs[win]) + 1) * 8 - 1; burst_own = win; end
                rr = 1 - win;
                rc[win] = 3'd0;
            end
            m_rvalid = nx_rvalid;
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_tie();
        test_blw_burst();
        test_fill_limits();
        test_tag_full();
        test_return();
        test_reset_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
